mem_transfer_sequencer: RTL and testbench
=========================================

Name: mem_transfer_sequencer

Overview:
- Multi-cycle sequencer directly upstream of the ALU system datapath; it drives that datapath's memory, IR, DR, ARF and MuxC control inputs.
- Runs three byte-serial transfers over the 8-bit memory port:
  - instruction fetch (PC -> IR, 2 bytes),
  - data load (AR -> DR, 1-4 bytes),
  - data store (ALUOut -> AR, 1-4 bytes).
- A start/busy/done handshake lets the future control unit issue one transfer and wait for it.

Parameters:
- MAX_BYTES, 4, maximum byte count for load/store. Fixed at 4 to match the 32-bit DR and ALUOut.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high; forces IDLE.
- Start  input  1  request strobe; sampled only in IDLE.
- Op  input  2  00 fetch instruction, 01 load to DR, 10 store from ALUOut, 11 reserved.
- ByteCount  input  2  number of bytes minus 1 (00 = 1 byte ... 11 = 4 bytes); ignored for fetch. Sampled with Start.
- Busy  output  1  high in every non-IDLE state.
- Done  output  1  one-cycle pulse when a transfer completes.
- Mem_CS  output  1  memory chip select, active-low (0 = enabled).
- Mem_WR  output  1  0 = read, 1 = write.
- IR_LH  output  1  0 = load IR[7:0], 1 = load IR[15:8].
- IR_Write  output  1  IR load enable.
- ARF_OutDSel  output  2  address source: 00 PC, 10 AR.
- ARF_FunSel  output  2  00 decrement, 01 increment, 10 load, 11 clear.
- ARF_RegSel  output  3  one-hot enables: 100 PC, 010 SP, 001 AR.
- DR_E  output  1  DR enable.
- DR_FunSel  output  2  01 clear and load low byte, 10 shift left 8 and load low byte.
- MuxCSel  output  2  selects the ALUOut byte driven to memory (00 = [7:0] ... 11 = [31:24]).

Behaviour:
- Idle output values (also the values after reset): Mem_CS=1, Mem_WR=0, IR_LH=0, IR_Write=0, ARF_OutDSel=00, ARF_FunSel=01, ARF_RegSel=000, DR_E=0, DR_FunSel=00, MuxCSel=00, Busy=0, Done=0.
- Outputs are Moore: decoded from the state register, the byte-index register and the latched count/op only. No combinational path from Start to any output.
- States: IDLE, FETCH_LO, FETCH_HI, LOAD, STORE, DONE.
- IDLE: on Start=1 latch Op and ByteCount, clear the byte index idx to 0, then:
  - Op 00 -> FETCH_LO
  - Op 01 -> LOAD
  - Op 10 -> STORE
  - Op 11 -> DONE, with no memory activity.
- FETCH_LO: Mem_CS=0, Mem_WR=0, ARF_OutDSel=00, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01. Next state FETCH_HI.
- FETCH_HI: same as FETCH_LO but IR_LH=1. Next state DONE.
  - Net effect: IR = {mem[PC+1], mem[PC]}, PC increases by 2.
- LOAD, one byte per cycle: Mem_CS=0, Mem_WR=0, ARF_OutDSel=10, DR_E=1, ARF_RegSel=001, ARF_FunSel=01.
  - DR_FunSel=01 when idx=0, otherwise 10.
  - The first byte read lands in the most-significant position of the N-byte value (big-endian). Bytes above N are zero.
- STORE, one byte per cycle: Mem_CS=0, Mem_WR=1, ARF_OutDSel=10, ARF_RegSel=001, ARF_FunSel=01, MuxCSel = ByteCount - idx (2-bit).
  - The most-significant of the N bytes goes to the lowest address (big-endian).
- LOAD/STORE loop: if idx == latched ByteCount -> DONE; otherwise idx increments and the state is held.
  - Length is N = ByteCount+1 cycles.
  - AR is incremented on every byte, so it ends at base+N.
- DONE: Done=1 and Busy=1 for exactly one cycle, all other outputs at idle values. Next state IDLE.
- Latency: Start accepted at edge k gives Done high in cycle k+1+T, where T = 2 for fetch, N for load/store, 0 for reserved.
  - A new Start is accepted in the cycle after Done, i.e. back-to-back spacing of T+2 cycles.
- Start while Busy=1 is ignored, with no queuing. Op/ByteCount changes while busy have no effect.
- ALUOut must be held stable by the controller for the duration of STORE; the sequencer does not capture it.
- Reset=1 at any edge: state <- IDLE, idx <- 0, latched Op/ByteCount <- 0.
  - Outputs take idle values after that edge; no Done pulse.
  - A partially completed transfer is abandoned; already-written bytes and register increments are not undone.
  - Reset has priority over Start in the same cycle.
- idx is 2 bits and never wraps, because ByteCount ≤ 3 bounds it.

Test Plan:
- Fetch: mem[0x0010]=0x34, mem[0x0011]=0x12, PC=0x0010; Start with Op=00 -> two cycles with Mem_CS=0, IR_LH 0 then 1. Then Done pulse, IR=0x1234, PC=0x0012, Busy high for exactly 3 cycles.
- Load 4: AR=0x0020, mem[0x20..0x23]=0xDE,0xAD,0xBE,0xEF; Op=01, ByteCount=11 -> DR_FunSel sequence 01,10,10,10. DR=0xDEADBEEF, AR=0x0024, Done in cycle k+5.
- Load 1: AR=0x0030, mem[0x30]=0x5A, DR pre-loaded 0xFFFFFFFF; Op=01, ByteCount=00 -> DR=0x0000005A, AR=0x0031, one LOAD cycle only.
- Store 3: ALUOut=0x00AABBCC held, AR=0x0040; Op=10, ByteCount=10 -> MuxCSel 10,01,00 with Mem_WR=1. mem[0x40..0x42]=0xAA,0xBB,0xCC, AR=0x0043.
- Handshake: Start held high through an entire fetch -> exactly one fetch. Op=11 -> Done at k+1 with Mem_CS=1 throughout. Start the cycle after Done -> accepted.
- Reset: assert Reset during the second byte of a 4-byte store -> next cycle Busy=0, Mem_CS=1, no Done. Start issued the following cycle runs normally.

Source files
------------

// File: rtl/mem_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// mem_transfer_sequencer
//
// Multi-cycle sequencer that sits directly in front of the ALU system datapath.
// It moves data one byte per cycle over the 8-bit memory port. It drives the
// memory, IR, DR, ARF and MuxC control inputs for three transfers:
//   - instruction fetch : mem[PC], mem[PC+1] -> IR (low byte first), PC += 2
//   - data load         : mem[AR..AR+N-1] -> DR, big-endian, AR += N
//   - data store        : ALUOut bytes -> mem[AR..AR+N-1], big-endian, AR += N
// The controller pulses Start in IDLE and then waits for the one-cycle Done.
//
// Ports
//   Clock        in   system clock, rising-edge active
//   Reset        in   synchronous, active-high; returns to IDLE
//   Start        in   request strobe, sampled only in IDLE
//   Op[1:0]      in   00 fetch, 01 load, 10 store, 11 reserved (no-op)
//   ByteCount    in   bytes minus 1 for load/store, latched with Start
//   Busy         out  high in every non-IDLE state
//   Done         out  one-cycle completion pulse
//   Mem_CS       out  memory chip select, active-low
//   Mem_WR       out  0 read, 1 write
//   IR_LH        out  0 loads IR[7:0], 1 loads IR[15:8]
//   IR_Write     out  IR load enable
//   ARF_OutDSel  out  address source: 00 PC, 10 AR
//   ARF_FunSel   out  00 dec, 01 inc, 10 load, 11 clear
//   ARF_RegSel   out  one-hot register enable: 100 PC, 010 SP, 001 AR
//   DR_E         out  DR enable
//   DR_FunSel    out  01 clear+load low byte, 10 shift left 8 + load low byte
//   MuxCSel      out  ALUOut byte driven to memory (00 = [7:0] .. 11 = [31:24])
//
// All outputs are Moore: they depend only on registered state.
// -----------------------------------------------------------------------------
module mem_transfer_sequencer #(
    parameter int MAX_BYTES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [1:0] Op,
    input  logic [1:0] ByteCount,
    output logic       Busy,
    output logic       Done,
    output logic       Mem_CS,
    output logic       Mem_WR,
    output logic       IR_LH,
    output logic       IR_Write,
    output logic [1:0] ARF_OutDSel,
    output logic [1:0] ARF_FunSel,
    output logic [2:0] ARF_RegSel,
    output logic       DR_E,
    output logic [1:0] DR_FunSel,
    output logic [1:0] MuxCSel
);

    localparam int IDX_W = $clog2(MAX_BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH_LO = 3'd1;
    localparam logic [2:0] S_FETCH_HI = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_STORE    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [1:0]       op_q,    op_d;
    logic [1:0]       bc_q,    bc_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        bc_d    = bc_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d  = Op;
                    bc_d  = ByteCount;
                    idx_d = '0;
                    case (Op)
                        OP_FETCH: state_d = S_FETCH_LO;
                        OP_LOAD:  state_d = S_LOAD;
                        OP_STORE: state_d = S_STORE;
                        default:  state_d = S_DONE;   // reserved: complete with no memory activity
                    endcase
                end
            end
            S_FETCH_LO: state_d = S_FETCH_HI;
            S_FETCH_HI: state_d = S_DONE;
            S_LOAD, S_STORE: begin
                // idx never wraps: it stops at the latched count, which is at most 3.
                if (idx_q == bc_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= 2'b00;
            bc_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            bc_q    <= bc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        Busy        = (state_q != S_IDLE);
        Done        = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b01;
        ARF_RegSel  = 3'b000;
        DR_E        = 1'b0;
        DR_FunSel   = 2'b00;
        MuxCSel     = 2'b00;

        case (state_q)
            S_FETCH_LO, S_FETCH_HI: begin
                // Read mem[PC] into one IR half and bump PC in the same cycle.
                Mem_CS     = 1'b0;
                IR_Write   = 1'b1;
                IR_LH      = (state_q == S_FETCH_HI);
                ARF_RegSel = 3'b100;
            end
            S_LOAD, S_STORE: begin
                // Both data transfers address through AR and increment it per byte;
                // the latched op selects direction.
                Mem_CS      = 1'b0;
                ARF_OutDSel = 2'b10;
                ARF_RegSel  = 3'b001;
                if (op_q == OP_STORE) begin
                    Mem_WR  = 1'b1;
                    // Most-significant selected byte goes first (lowest address).
                    MuxCSel = bc_q - idx_q;
                end else begin
                    DR_E      = 1'b1;
                    // First byte clears DR; later bytes shift earlier ones upward,
                    // so the first byte ends up most significant.
                    DR_FunSel = (idx_q == '0) ? 2'b01 : 2'b10;
                end
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mem_transfer_sequencer.
// A small behavioural model of the memory, PC, AR, IR and DR sits beside the
// DUT. The model applies the DUT's control outputs the way the real datapath
// would at the next rising edge. A vector table covers the cycle-by-cycle
// control patterns. Hand-written sequences cover the data results and the
// reset-abort case.
// -----------------------------------------------------------------------------
module tb_mem_transfer_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [1:0] Op;
    logic [1:0] ByteCount;
    logic       Busy;
    logic       Done;
    logic       Mem_CS;
    logic       Mem_WR;
    logic       IR_LH;
    logic       IR_Write;
    logic [1:0] ARF_OutDSel;
    logic [1:0] ARF_FunSel;
    logic [2:0] ARF_RegSel;
    logic       DR_E;
    logic [1:0] DR_FunSel;
    logic [1:0] MuxCSel;

    mem_transfer_sequencer #(.MAX_BYTES(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Op          (Op),
        .ByteCount   (ByteCount),
        .Busy        (Busy),
        .Done        (Done),
        .Mem_CS      (Mem_CS),
        .Mem_WR      (Mem_WR),
        .IR_LH       (IR_LH),
        .IR_Write    (IR_Write),
        .ARF_OutDSel (ARF_OutDSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .DR_E        (DR_E),
        .DR_FunSel   (DR_FunSel),
        .MuxCSel     (MuxCSel)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Control word packing: {Busy, Done, Mem_CS, Mem_WR, IR_LH, IR_Write,
    // ARF_OutDSel, ARF_FunSel, ARF_RegSel, DR_E, DR_FunSel, MuxCSel}
    localparam logic [17:0] C_IDLE = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00};
    localparam logic [17:0] C_DONE = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00};
    localparam logic [17:0] C_FLO  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'b100, 1'b0, 2'b00, 2'b00};
    localparam logic [17:0] C_FHI  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 3'b100, 1'b0, 2'b00, 2'b00};
    localparam logic [17:0] C_LD0  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 3'b001, 1'b1, 2'b01, 2'b00};
    localparam logic [17:0] C_LDN  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 3'b001, 1'b1, 2'b10, 2'b00};

    typedef struct {
        logic        start;
        logic [1:0]  op;
        logic [1:0]  bc;
        logic [17:0] exp_ctl;   // outputs expected during this cycle
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    // Datapath model
    logic [7:0]  mem [256];
    logic [15:0] pc, ar;
    logic [15:0] ir;
    logic [31:0] dr;
    logic [31:0] alu_out;

    function automatic logic [17:0] ctl_word();
        return {Busy, Done, Mem_CS, Mem_WR, IR_LH, IR_Write,
                ARF_OutDSel, ARF_FunSel, ARF_RegSel, DR_E, DR_FunSel, MuxCSel};
    endfunction

    function automatic logic [15:0] arf_op(input logic [15:0] r, input logic [1:0] fs);
        case (fs)
            2'b00:   return r - 16'd1;
            2'b01:   return r + 16'd1;
            2'b10:   return r;
            default: return 16'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply what the datapath does at the coming rising edge, given the
    // outputs now on the control lines.
    task automatic model_step();
        logic [15:0] addr;
        logic [7:0]  rd;
        addr = (ARF_OutDSel == 2'b10) ? ar : pc;
        rd   = mem[addr[7:0]];
        if (Mem_CS === 1'b0 && Mem_WR === 1'b1)
            mem[addr[7:0]] = alu_out[MuxCSel*8 +: 8];
        if (IR_Write === 1'b1 && Mem_CS === 1'b0) begin
            if (IR_LH) ir[15:8] = rd;
            else       ir[7:0]  = rd;
        end
        if (DR_E === 1'b1 && Mem_CS === 1'b0) begin
            if (DR_FunSel == 2'b01)      dr = {24'h0, rd};
            else if (DR_FunSel == 2'b10) dr = {dr[23:0], rd};
        end
        if (ARF_RegSel[2] === 1'b1) pc = arf_op(pc, ARF_FunSel);
        if (ARF_RegSel[0] === 1'b1) ar = arf_op(ar, ARF_FunSel);
    endtask

    // Advance to the next sampling point (falling edge).
    task automatic tick();
        @(negedge Clock);
        model_step();
    endtask

    // Issue one request and follow it to Done, recording what happened.
    task automatic run_xfer(input logic [1:0] op, input logic [1:0] bc,
                            output int cycles, output int ld_cycles,
                            output int wr_cycles, output logic [7:0] mux_trace);
        logic done_seen;
        Start     = 1'b1;
        Op        = op;
        ByteCount = bc;
        tick();
        Start     = 1'b0;
        cycles    = 0;
        ld_cycles = 0;
        wr_cycles = 0;
        mux_trace = 8'h00;
        done_seen = 1'b0;
        while (!done_seen && cycles < 20) begin
            cycles++;
            if (!Mem_CS && DR_E)   ld_cycles++;
            if (!Mem_CS && Mem_WR) begin
                wr_cycles++;
                mux_trace = {mux_trace[5:0], MuxCSel};
            end
            if (Done) done_seen = 1'b1;
            else      tick();
        end
        check("xfer_done_seen", {31'd0, done_seen}, 32'd1);
        tick();   // move into IDLE
    endtask

    initial begin
        int          cyc, ldc, wrc;
        logic [7:0]  mtr;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        mem[8'h12] = 8'h78; mem[8'h13] = 8'h56;
        mem[8'h20] = 8'hDE; mem[8'h21] = 8'hAD; mem[8'h22] = 8'hBE; mem[8'h23] = 8'hEF;
        mem[8'h30] = 8'h5A;
        pc = 16'h0010; ar = 16'h0020; ir = 16'h0000; dr = 32'h0; alu_out = 32'h0;

        // Fetch with Start held through it, reserved op, then a load-4 issued
        // the cycle after Done while Op/ByteCount wander during the transfer.
        vecs[0]  = '{1'b1, 2'b00, 2'b00, C_IDLE};
        vecs[1]  = '{1'b1, 2'b00, 2'b00, C_FLO};
        vecs[2]  = '{1'b1, 2'b00, 2'b00, C_FHI};
        vecs[3]  = '{1'b0, 2'b00, 2'b00, C_DONE};
        vecs[4]  = '{1'b1, 2'b11, 2'b00, C_IDLE};
        vecs[5]  = '{1'b1, 2'b01, 2'b11, C_DONE};
        vecs[6]  = '{1'b1, 2'b01, 2'b11, C_IDLE};
        vecs[7]  = '{1'b1, 2'b10, 2'b00, C_LD0};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, C_LDN};
        vecs[9]  = '{1'b0, 2'b00, 2'b00, C_LDN};
        vecs[10] = '{1'b0, 2'b00, 2'b00, C_LDN};
        vecs[11] = '{1'b0, 2'b00, 2'b00, C_DONE};
        vecs[12] = '{1'b0, 2'b00, 2'b00, C_IDLE};

        Reset = 1'b1; Start = 1'b0; Op = 2'b00; ByteCount = 2'b00;
        tick();
        tick();
        Reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            tick();
            check($sformatf("vec%0d_ctl", i), {14'd0, ctl_word()}, {14'd0, vecs[i].exp_ctl});
            Start     = vecs[i].start;
            Op        = vecs[i].op;
            ByteCount = vecs[i].bc;
        end
        check("fetch_ir", {16'd0, ir}, 32'h0000_1234);
        check("fetch_pc", {16'd0, pc}, 32'h0000_0012);
        check("load4_dr", dr, 32'hDEAD_BEEF);
        check("load4_ar", {16'd0, ar}, 32'h0000_0024);

        // Load 1 byte over a preloaded DR.
        tick();
        ar = 16'h0030; dr = 32'hFFFF_FFFF;
        run_xfer(2'b01, 2'b00, cyc, ldc, wrc, mtr);
        check("load1_dr", dr, 32'h0000_005A);
        check("load1_ar", {16'd0, ar}, 32'h0000_0031);
        check("load1_ld_cycles", ldc, 1);
        check("load1_latency", cyc, 2);

        // Store 3 bytes, big-endian.
        ar = 16'h0040; alu_out = 32'h00AA_BBCC;
        run_xfer(2'b10, 2'b10, cyc, ldc, wrc, mtr);
        check("store3_mux_seq", {26'd0, mtr[5:0]}, 32'h0000_0024);  // 10,01,00
        check("store3_wr_cycles", wrc, 3);
        check("store3_latency", cyc, 4);
        check("store3_mem", {8'h00, mem[8'h40], mem[8'h41], mem[8'h42]}, 32'h00AA_BBCC);
        check("store3_ar", {16'd0, ar}, 32'h0000_0043);

        // Reset during the second byte of a 4-byte store.
        ar = 16'h0050; alu_out = 32'h1122_3344;
        Start = 1'b1; Op = 2'b10; ByteCount = 2'b11;
        tick();
        Start = 1'b0;
        check("rst_store_b0_mux", {30'd0, MuxCSel}, 32'd3);
        tick();
        check("rst_store_b1_mux", {30'd0, MuxCSel}, 32'd2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_cs", {31'd0, Mem_CS}, 32'd1);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_partial_mem", {8'h00, mem[8'h50], mem[8'h51], mem[8'h52]}, 32'h0011_2200);
        check("rst_partial_ar", {16'd0, ar}, 32'h0000_0052);
        run_xfer(2'b00, 2'b00, cyc, ldc, wrc, mtr);
        check("post_rst_fetch_ir", {16'd0, ir}, 32'h0000_5678);
        check("post_rst_fetch_pc", {16'd0, pc}, 32'h0000_0014);
        check("post_rst_fetch_latency", cyc, 3);
        check("post_rst_idle", {14'd0, ctl_word()}, {14'd0, C_IDLE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
